left_register: RTL and testbench
================================

# left_register

Sender-side elastic register: accepts words from a local producer, buffers them, and drives them onto the valid/ready link toward the receiver-side elastic register (`data_left`/`vld_left`/`rdy_left` wire directly to that block's `data_right`/`vld_right`/`rdy_right`). It has a registered output stage, so `data_left` and `vld_left` come straight from flops. There is no combinational path from `rdy_left` to `ready_o`. It also counts completed link transfers for bring-up and debug.

## Interface
- `DW_left`, 16: data width in bits.
- `DEPTH_left`, 4: storage FIFO entries, a power of two, ≥2. Total capacity is `DEPTH_left`+1 (FIFO plus output register).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst`=0 resets).
- `din_i`  in  `DW_left`  producer data.
- `valid_i`  in  1  producer data valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `data_left`  out  `DW_left`  link data (registered).
- `vld_left`  out  1  link valid (registered).
- `rdy_left`  in  1  receiver ready.
- `level_o`  out  `$clog2(DEPTH_left+2)`  words held: FIFO count plus output-register occupancy.
- `sent_cnt_o`  out  16  completed link transfers, modulo 2^16.

## Operation
- Accept: `valid_i && ready_o`. Send: `vld_left && rdy_left`.
- `ready_o` = (FIFO count < `DEPTH_left`) && `rst`. It depends on registered state only, plus the reset gate.
- Output stage FSM, states `OUT_EMPTY` and `OUT_FULL`:
  - `OUT_EMPTY` → `OUT_FULL` when an accept occurs or the FIFO is non-empty.
  - `OUT_FULL` → `OUT_EMPTY` on a send, if the FIFO is empty and there is no accept that cycle.
  - In all other cases the state is held.
- Output register load priority, evaluated when the register is empty or being sent:
  1. FIFO head (pop), if the FIFO is non-empty.
  2. Otherwise `din_i` on an accept (bypass).
  3. Otherwise no load.
- An accept that is not bypassed pushes into the FIFO at the tail.
- Head and tail pointers are `$clog2(DEPTH_left)` bits and wrap naturally from `DEPTH_left`-1 to 0.
- Ordering is strict FIFO. Words are never duplicated, dropped or reordered.
- Link hold rule: once `vld_left`=1, `vld_left` and `data_left` stay stable until a send.
- `sent_cnt_o` increments by 1 on each send and wraps from 16'hFFFF to 0.
- `level_o` increments on accept-only, decrements on send-only, and is unchanged when both or neither occur.

## Timing
- Reset values, one cycle after `rst`=0 sampled: `vld_left`=0, `data_left`=0, `level_o`=0, `sent_cnt_o`=0, pointers 0, FSM `OUT_EMPTY`.
- `ready_o`=0 while `rst`=0. It returns to 1 in the first cycle with `rst`=1.
- Latency when empty: a word accepted at edge N is on `data_left` with `vld_left`=1 after edge N; it is sendable in cycle N+1.
- Throughput: one word per cycle sustained when `rdy_left`=1 continuously.
- FIFO full with a send in the same cycle: `ready_o` stays 0 that cycle. The pop frees an entry, and `ready_o`=1 from the next cycle.
- Simultaneous push and pop with a non-empty FIFO: the count is unchanged and both pointers advance.
- Reset mid-operation: all buffered words are discarded with no partial send. `sent_cnt_o` clears.
- `valid_i` high with `ready_o` low: the word is not taken, and the producer must hold it.

## Structure
- Package `left_register_pkg` holds:
  - `typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e`
  - `localparam int SENT_CNT_W = 16`
- Sub-module `left_fifo_mem`: storage array with head/tail pointers, count, and push/pop ports.
- The top level holds the output-stage FSM, bypass mux, level and transfer counters.

## Test plan
- Reset check: drive `rst`=0 for 3 cycles with `valid_i`=1 → `ready_o`=0, `vld_left`=0, `level_o`=0, `sent_cnt_o`=0. After release, first word 16'h0001 appears on `data_left` one cycle after its accept.
- Backpressure fill: hold `rdy_left`=0 and push 16'h0010..16'h0014 (5 words, `DEPTH_left`=4) → `ready_o` drops after the 5th accept, `level_o`=5, and `data_left` holds 16'h0010 throughout. Release `rdy_left` → words 0x10..0x14 are received in order on 5 consecutive cycles, then `sent_cnt_o`=5.
- Full plus simultaneous send: with 5 words stored, assert `rdy_left` while `valid_i`=1 → `ready_o`=0 in that cycle and 1 in the next. `level_o` goes 5→4→4 as the following accept and send coincide.
- Streaming: `valid_i`=1 and `rdy_left`=1 for 20 cycles with an incrementing pattern → 1 word per cycle, `level_o` stays 1, and there are no gaps or duplicates after the first cycle.
- Pointer wrap and counter wrap: preload `sent_cnt_o` to 16'hFFFE via 65534 random-backpressure transfers, then send 3 more → `sent_cnt_o` reads 16'hFFFF, then 0, then 1. Data order is intact across multiple pointer wraps.
- Reset mid-burst: with 3 words buffered and `vld_left`=1, pulse `rst`=0 for 1 cycle → `vld_left`=0 and `level_o`=0 next cycle. A new word 16'hABCD sent afterwards is the first word received.

Source files
------------

// File: rtl/left_register_pkg.sv
// Shared types for the sender-side elastic register.
// Output-stage state encoding and counter width.
package left_register_pkg;

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } out_state_e;

   localparam int SENT_CNT_W = 16;

endpackage

// File: rtl/left_fifo_mem.sv
// Circular storage FIFO behind the output register.
// Head/tail wrap naturally; count tracks occupancy.
import left_register_pkg::*;

module left_fifo_mem #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   assign dout = mem[head];

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/left_register.sv
// Sender-side elastic register: FIFO plus registered output stage,
// driving the valid/ready link and counting completed transfers.
import left_register_pkg::*;

module left_register #(
   parameter int DW_left    = 16,
   parameter int DEPTH_left = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DW_left-1:0]                din_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic [DW_left-1:0]                data_left,
   output logic                              vld_left,
   input  logic                              rdy_left,
   output logic [$clog2(DEPTH_left+2)-1:0]   level_o,
   output logic [SENT_CNT_W-1:0]             sent_cnt_o
);

   localparam int CW = $clog2(DEPTH_left + 1);
   localparam int LW = $clog2(DEPTH_left + 2);

   out_state_e        state;
   out_state_e        state_nxt;
   logic [CW-1:0]     fifo_count;
   logic [DW_left-1:0] fifo_dout;
   logic [DW_left-1:0] data_q;
   logic [LW-1:0]     level_q;
   logic [SENT_CNT_W-1:0] sent_q;
   logic              accept;
   logic              send;
   logic              fifo_ne;
   logic              load_en;
   logic              pop;
   logic              bypass;
   logic              push;

   // ready depends only on the FIFO count flops, never on rdy_left
   assign ready_o    = (fifo_count < CW'(DEPTH_left)) && rst;
   assign vld_left   = (state == OUT_FULL);
   assign data_left  = data_q;
   assign level_o    = level_q;
   assign sent_cnt_o = sent_q;

   assign accept  = valid_i && ready_o;
   assign send    = vld_left && rdy_left;
   assign fifo_ne = (fifo_count != '0);
   assign load_en = (state == OUT_EMPTY) || send;
   assign pop     = load_en && fifo_ne;
   assign bypass  = load_en && !fifo_ne && accept;
   assign push    = accept && !bypass;

   left_fifo_mem #(
      .DW    (DW_left),
      .DEPTH (DEPTH_left),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din_i),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         OUT_EMPTY: if (accept || fifo_ne) state_nxt = OUT_FULL;
         OUT_FULL:  if (send && !fifo_ne && !accept) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= OUT_EMPTY;
         data_q  <= '0;
         level_q <= '0;
         sent_q  <= '0;
      end else begin
         state <= state_nxt;
         if (pop)         data_q <= fifo_dout;
         else if (bypass) data_q <= din_i;
         unique case ({accept, send})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
         if (send) sent_q <= sent_q + SENT_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_left_register.sv
// Bench for left_register: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_left_register;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] din_i = '0;
   logic        valid_i = 1'b0;
   logic        rdy_left = 1'b0;
   logic        ready_o;
   logic [15:0] data_left;
   logic        vld_left;
   logic [2:0]  level_o;
   logic [15:0] sent_cnt_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] q[$];
   logic [15:0] m_sent;

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        r;
      logic        e_rdy;
      logic        e_vld;
      logic [15:0] e_data;
      logic [2:0]  e_lvl;
      logic [15:0] e_sent;
   } vec_t;

   vec_t tbl[13];

   left_register #(
      .DW_left    (16),
      .DEPTH_left (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din_i      (din_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_left  (data_left),
      .vld_left   (vld_left),
      .rdy_left   (rdy_left),
      .level_o    (level_o),
      .sent_cnt_o (sent_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: q holds every buffered word, oldest first; the oldest
   // one is what the link shows.  Capacity is DEPTH+1 words.
   task automatic model_cycle(input logic r, input logic v,
                              input logic [15:0] d, input logic rd);
      logic exp_rdy;
      logic acc;
      logic snd;
      rst = r;
      valid_i = v;
      din_i = d;
      rdy_left = rd;
      #1;
      exp_rdy = r && (q.size() <= DEPTH);
      chk("ready_o", 32'(ready_o), 32'(exp_rdy));
      chk("vld_left", 32'(vld_left), 32'(q.size() > 0));
      if (q.size() > 0) chk("data_left", 32'(data_left), 32'(q[0]));
      chk("level_o", 32'(level_o), 32'(q.size()));
      chk("sent_cnt_o", 32'(sent_cnt_o), 32'(m_sent));
      acc = v && exp_rdy;
      snd = (q.size() > 0) && rd;
      @(posedge clk);
      #1;
      if (!r) begin
         q.delete();
         m_sent = '0;
      end else begin
         if (snd) begin
            void'(q.pop_front());
            m_sent = m_sent + 16'd1;
         end
         if (acc) q.push_back(d);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0010, 3'd1, 16'd0};
      tbl[1]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 16'h0010, 3'd2, 16'd0};
      tbl[2]  = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b1, 16'h0010, 3'd3, 16'd0};
      tbl[3]  = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 16'h0010, 3'd4, 16'd0};
      tbl[4]  = '{1'b1, 16'h0014, 1'b0, 1'b1, 1'b1, 16'h0010, 3'd5, 16'd0};
      tbl[5]  = '{1'b1, 16'h0015, 1'b0, 1'b0, 1'b1, 16'h0010, 3'd5, 16'd0};
      tbl[6]  = '{1'b1, 16'h0015, 1'b1, 1'b0, 1'b1, 16'h0011, 3'd4, 16'd1};
      tbl[7]  = '{1'b1, 16'h0015, 1'b1, 1'b1, 1'b1, 16'h0012, 3'd4, 16'd2};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0013, 3'd3, 16'd3};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0014, 3'd2, 16'd4};
      tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0015, 3'd1, 16'd5};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 16'd6};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 16'd6};

      // reset held with valid_i asserted
      rst = 1'b0;
      valid_i = 1'b1;
      din_i = 16'h0055;
      tick();
      q.delete();
      m_sent = '0;
      repeat (2) model_cycle(1'b0, 1'b1, 16'h0055, 1'b0);
      chk("rst_vld", 32'(vld_left), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_sent", 32'(sent_cnt_o), 32'd0);

      model_cycle(1'b1, 1'b1, 16'h0001, 1'b0);
      chk("first_vld", 32'(vld_left), 32'd1);
      chk("first_word", 32'(data_left), 32'h0001);
      model_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      chk("first_sent", 32'(sent_cnt_o), 32'd1);

      // backpressure fill, full plus send, drain
      model_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 13; i++) begin
         rst = 1'b1;
         valid_i = tbl[i].v;
         din_i = tbl[i].d;
         rdy_left = tbl[i].r;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_rdy));
         tick();
         chk($sformatf("tbl%0d_vld", i), 32'(vld_left), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld)
            chk($sformatf("tbl%0d_data", i), 32'(data_left),
                32'(tbl[i].e_data));
         chk($sformatf("tbl%0d_level", i), 32'(level_o), 32'(tbl[i].e_lvl));
         chk($sformatf("tbl%0d_sent", i), 32'(sent_cnt_o),
             32'(tbl[i].e_sent));
      end
      q.delete();
      m_sent = 16'd6;

      // reset mid-burst
      model_cycle(1'b1, 1'b1, 16'h00A1, 1'b0);
      model_cycle(1'b1, 1'b1, 16'h00A2, 1'b0);
      model_cycle(1'b1, 1'b1, 16'h00A3, 1'b0);
      chk("burst_vld", 32'(vld_left), 32'd1);
      chk("burst_level", 32'(level_o), 32'd3);
      model_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("midrst_vld", 32'(vld_left), 32'd0);
      chk("midrst_level", 32'(level_o), 32'd0);
      chk("midrst_sent", 32'(sent_cnt_o), 32'd0);
      model_cycle(1'b1, 1'b1, 16'hABCD, 1'b0);
      chk("after_rst_word", 32'(data_left), 32'hABCD);
      model_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      chk("after_rst_sent", 32'(sent_cnt_o), 32'd1);

      // mixed random traffic, filling and draining
      for (int c = 0; c < 1000; c++)
         model_cycle(1'b1, $urandom_range(3) != 0, 16'($urandom),
                     $urandom_range(3) == 0);
      for (int c = 0; c < 1000; c++)
         model_cycle(1'b1, $urandom_range(1) != 0, 16'($urandom),
                     $urandom_range(1) != 0);

      // streaming
      repeat (6) model_cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         model_cycle(1'b1, 1'b1, 16'(16'h0100 + i), 1'b1);
         chk("stream_level", 32'(level_o), 32'd1);
         chk("stream_data", 32'(data_left), 32'(16'h0100 + i));
      end

      // run the transfer counter up to 16'hFFFE
      for (int c = 0; c < 90000 && m_sent != 16'hFFFE; c++)
         model_cycle(1'b1, $urandom_range(63) != 0, 16'($urandom),
                     $urandom_range(63) != 0);
      chk("preload_reached", 32'(m_sent), 32'hFFFE);
      model_cycle(1'b1, 1'b1, 16'h0C01, 1'b0);
      model_cycle(1'b1, 1'b1, 16'h0C02, 1'b1);
      chk("wrap_ffff", 32'(sent_cnt_o), 32'hFFFF);
      model_cycle(1'b1, 1'b1, 16'h0C03, 1'b1);
      chk("wrap_0000", 32'(sent_cnt_o), 32'h0000);
      model_cycle(1'b1, 1'b1, 16'h0C04, 1'b1);
      chk("wrap_0001", 32'(sent_cnt_o), 32'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
